mc_maindec: RTL and testbench
=============================

MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 The block SHALL have no parameters; state encoding is fixed (FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces FETCH.
REQ-005 op  in  6  opcode from the instruction register; stable from DECODE to the return to FETCH.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory access completes this cycle.
REQ-008 aluop  out  2  ALU operation class for the ALU function decoder: 00 add, 01 sub, 10 use funct.
REQ-009 alusrca out 1; alusrcb out 2; pcsrc out 2; iord, irwrite, regdst, memtoreg, regwrite, memwrite, branch, pcwrite out 1 each: the multicycle datapath controls.
REQ-010 pcen  out  1  PC write enable, computed as pcwrite | (branch & zero).
REQ-011 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-012 state  out  4  current state, for debug.

Function
REQ-013 The block SHALL be a Moore FSM with one registered state; all outputs decode from state, except FETCH write enables (mem_ready) and pcen (zero).
REQ-014 Any control not listed for a state SHALL be 0.
REQ-015 FETCH outputs SHALL be: alusrcb=01, irwrite=pcwrite=mem_ready. FETCH SHALL go to DECODE if mem_ready=1 and stay otherwise.
REQ-016 DECODE outputs SHALL be alusrcb=11, aluop=00. Next state by op:
- 100011 (lw) or 101011 (sw): MEMADR.
- 000000 (R-type): EXECUTE.
- 000100 (beq): BRANCH.
- 001000 (addi): ADDIEX.
- 000010 (j): JUMP.
- any other op: FETCH, with illegal_op=1 in DECODE.
REQ-017 MEMADR outputs SHALL be alusrca=1, alusrcb=10. MEMADR SHALL go to MEMRD if op=lw and to MEMWR if op=sw.
REQ-018 MEMRD outputs SHALL be iord=1. MEMRD SHALL go to MEMWB if mem_ready=1 and stay otherwise.
REQ-019 MEMWB outputs SHALL be memtoreg=1, regwrite=1. MEMWB SHALL go to FETCH.
REQ-020 MEMWR outputs SHALL be iord=1, memwrite=1, held for the entire stall. MEMWR SHALL go to FETCH if mem_ready=1.
REQ-021 EXECUTE outputs SHALL be alusrca=1, alusrcb=00, aluop=10. EXECUTE SHALL go to ALUWB.
REQ-022 ALUWB outputs SHALL be regdst=1, regwrite=1. ALUWB SHALL go to FETCH.
REQ-023 BRANCH outputs SHALL be alusrca=1, aluop=01, pcsrc=01, branch=1. BRANCH SHALL go to FETCH.
REQ-024 ADDIEX outputs SHALL be alusrca=1, alusrcb=10. ADDIEX SHALL go to ADDIWB.
REQ-025 ADDIWB outputs SHALL be regwrite=1. ADDIWB SHALL go to FETCH.
REQ-026 JUMP outputs SHALL be pcsrc=10, pcwrite=1. JUMP SHALL go to FETCH.
REQ-027 Instruction latency in cycles, with mem_ready=1 throughout, SHALL be:
- lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
REQ-028 Unreachable encodings 12-15 SHALL go to FETCH on the next edge with all controls 0.

Reset
REQ-029 reset=0 SHALL force state=FETCH immediately, independent of clk, including mid-instruction.
REQ-030 While reset=0, all outputs SHALL read:
- regwrite, memwrite, irwrite, pcwrite, pcen, illegal_op: 0.
- alusrcb: 01; all other outputs: 0.
REQ-031 On the first rising clk after reset deasserts, FETCH behaviour SHALL resume.

Verification
REQ-032 Reset release, mem_ready=1, op=100011: state 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-033 sw with mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 consecutive cycles, then state=0.
REQ-034 beq, zero=1 in BRANCH: pcen=1, pcsrc=01, aluop=01; repeat with zero=0: pcen=0.
REQ-035 op=111111 in DECODE: illegal_op=1 for exactly 1 cycle; next state 0; regwrite and memwrite never 1.
REQ-036 reset pulsed low during MEMRD: state=0 asynchronously, all write enables 0; the FETCH stall with mem_ready=0 holds irwrite=0.

Source files
------------

// File: rtl/mc_maindec.sv
// mc_maindec: main control FSM for a multicycle load/store datapath.
// Moore outputs decode from the registered state. The exceptions are the
// FETCH write enables, which follow mem_ready, and pcen, which folds in zero.
//
//  state   | meaning
//  --------+---------------------------------------------------
//  FETCH   | read instruction, PC+4; waits on mem_ready
//  DECODE  | register read, branch target; dispatch on op
//  MEMADR  | compute load/store address
//  MEMRD   | data read; waits on mem_ready
//  MEMWB   | write loaded data to register file
//  MEMWR   | data write, held until mem_ready
//  EXECUTE | R-type ALU operation
//  ALUWB   | write R-type result (rd)
//  BRANCH  | beq compare, conditional PC update
//  ADDIEX  | addi ALU operation
//  ADDIWB  | write addi result (rt)
//  JUMP    | unconditional PC update
module mc_maindec (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       memwrite,
    output logic       branch,
    output logic       pcwrite,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // State register; reset drops straight to FETCH regardless of clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; unused encodings recover to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // op cannot change after DECODE, so only lw/sw arrive here;
            // anything else is abandoned rather than guessed at.
            MEMADR: begin
                if (op == OP_LW) begin
                    state_d = MEMRD;
                end else if (op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Datapath control decode; everything not named for a state stays 0.
    always_comb begin
        aluop      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        branch     = 1'b0;
        pcwrite    = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                // Gated by reset so a held-in-reset core never latches IR/PC.
                irwrite = mem_ready & reset;
                pcwrite = mem_ready & reset;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                aluop = 2'b00;
            end
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: instruction-level model of the main decoder compared every
// cycle, plus directed literal checks on traces, latencies and reset.
module tb_mc_maindec;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord, irwrite, regdst, memtoreg, regwrite, memwrite;
    logic       branch, pcwrite, pcen, illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int m_idx    = 0;

    int         lw_seq [5] = '{1, 2, 3, 4, 0};
    logic [5:0] lat_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    int         lat_exp[6] = '{5, 4, 4, 4, 3, 3};

    mc_maindec dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .aluop      (aluop),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .branch     (branch),
        .pcwrite    (pcwrite),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of cycles an instruction takes with no memory stalls.
    function automatic int seq_len(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Phase i of the instruction with opcode o.
    function automatic logic [3:0] seq_state(input logic [5:0] o, input int i);
        if (i == 0) return 4'd0;
        if (i == 1) return 4'd1;
        case (o)
            6'b100011: return (i == 2) ? 4'd2 : ((i == 3) ? 4'd3 : 4'd4);
            6'b101011: return (i == 2) ? 4'd2 : 4'd5;
            6'b000000: return (i == 2) ? 4'd6 : 4'd7;
            6'b001000: return (i == 2) ? 4'd9 : 4'd10;
            6'b000100: return 4'd8;
            6'b000010: return 4'd11;
            default:   return 4'd0;
        endcase
    endfunction

    function automatic logic [20:0] exp_out(input logic [3:0] st, input logic mr,
                                            input logic z, input logic rst, input logic ill);
        logic [1:0] a_op = 2'b00;
        logic [1:0] srcb = 2'b00;
        logic [1:0] psrc = 2'b00;
        logic srca = 1'b0, io = 1'b0, irw = 1'b0, rdst = 1'b0, m2r = 1'b0;
        logic rw = 1'b0, mw = 1'b0, br = 1'b0, pcw = 1'b0, il = 1'b0;
        case (st)
            4'd0:  begin srcb = 2'b01; irw = mr & rst; pcw = mr & rst; end
            4'd1:  begin srcb = 2'b11; il = ill; end
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; end
            4'd6:  begin srca = 1'b1; a_op = 2'b10; end
            4'd7:  begin rdst = 1'b1; rw = 1'b1; end
            4'd8:  begin srca = 1'b1; a_op = 2'b01; psrc = 2'b01; br = 1'b1; end
            4'd9:  begin srca = 1'b1; srcb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin psrc = 2'b10; pcw = 1'b1; end
            default: il = 1'b0;
        endcase
        return {st, a_op, srca, srcb, psrc, io, irw, rdst, m2r, rw, mw, br, pcw, pcw | (br & z), il};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the instruction-phase model, then advance it.
    task automatic compare_loop();
        logic [20:0] e;
        logic [20:0] a;
        logic [3:0]  st;
        forever begin
            @(negedge clk);
            if (!reset) m_idx = 0;
            st = seq_state(op, m_idx);
            e  = exp_out(st, mem_ready, zero, reset, seq_len(op) == 2);
            a  = {state, aluop, alusrca, alusrcb, pcsrc, iord, irwrite, regdst, memtoreg,
                  regwrite, memwrite, branch, pcwrite, pcen, illegal_op};
            chk("cycle_outputs", 32'(a), 32'(e));
            if (reset) begin
                if (!((st == 4'd0 || st == 4'd3 || st == 4'd5) && !mem_ready)) begin
                    m_idx++;
                    if (m_idx >= seq_len(op)) m_idx = 0;
                end
            end
        end
    endtask

    initial begin
        int n;
        int wcnt;
        reset     = 1'b0;
        op        = 6'b100011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        fork
            compare_loop();
        join_none

        #12;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_alusrcb", 32'(alusrcb), 32'd1);
        chk("rst_irwrite", 32'(irwrite), 32'd0);
        chk("rst_pcwrite", 32'(pcwrite), 32'd0);
        chk("rst_pcen",    32'(pcen),    32'd0);
        tick();
        reset = 1'b1;

        // lw trace with no stalls
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lw_state", 32'(state), 32'(lw_seq[i]));
            if (i == 3) begin
                chk("lw_regwrite", 32'(regwrite), 32'd1);
                chk("lw_memtoreg", 32'(memtoreg), 32'd1);
            end
        end

        // sw with three stall cycles in MEMWR
        op = 6'b101011;
        tick();
        tick();
        chk("sw_memadr", 32'(state), 32'd2);
        mem_ready = 1'b0;
        tick();
        wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            if (memwrite) wcnt++;
            tick();
        end
        chk("sw_memwrite_cycles", 32'(wcnt), 32'd4);
        chk("sw_done_state", 32'(state), 32'd0);

        // latency of each supported instruction
        for (int k = 0; k < 6; k++) begin
            op = lat_ops[k];
            n  = 0;
            do begin
                tick();
                n++;
            end while (state != 4'd0 && n < 20);
            chk("latency", 32'(n), 32'(lat_exp[k]));
        end

        // beq taken then not taken
        op   = 6'b000100;
        zero = 1'b1;
        tick();
        tick();
        chk("beq_state", 32'(state), 32'd8);
        chk("beq_pcen_taken", 32'(pcen), 32'd1);
        chk("beq_pcsrc", 32'(pcsrc), 32'd1);
        chk("beq_aluop", 32'(aluop), 32'd1);
        tick();
        zero = 1'b0;
        tick();
        tick();
        chk("beq_pcen_not_taken", 32'(pcen), 32'd0);
        tick();

        // unsupported opcode
        op = 6'b111111;
        tick();
        chk("illegal_pulse", 32'(illegal_op), 32'd1);
        tick();
        chk("illegal_after", 32'(illegal_op), 32'd0);
        chk("illegal_next_state", 32'(state), 32'd0);
        op = 6'b100011;

        // reset during a stalled MEMRD, then FETCH stall after release
        tick();
        tick();
        tick();
        chk("memrd_state", 32'(state), 32'd3);
        mem_ready = 1'b0;
        tick();
        chk("memrd_stall", 32'(state), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_state",    32'(state),    32'd0);
        chk("async_rst_regwrite", 32'(regwrite), 32'd0);
        chk("async_rst_memwrite", 32'(memwrite), 32'd0);
        chk("async_rst_irwrite",  32'(irwrite),  32'd0);
        chk("async_rst_pcwrite",  32'(pcwrite),  32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("fetch_stall_irwrite", 32'(irwrite), 32'd0);
        tick();
        chk("fetch_stall_state",   32'(state),   32'd0);
        chk("fetch_stall_irwrite2", 32'(irwrite), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("fetch_ready_irwrite", 32'(irwrite), 32'd1);
        tick();
        chk("fetch_resume_state", 32'(state), 32'd1);
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
